// File: rtl/flash_read_arbiter.sv
// flash_read_arbiter
//   Shares one read-only flash read port between two requesters. A winner is
//   picked in IDLE, its address/length are latched, the flash is started with
//   a one-cycle flash_rd pulse, returning bytes are forwarded combinationally
//   to the owner, and the read is closed with a one-cycle flash_halt_rd
//   followed by RECOVER_CYCLES idle cycles before the next grant.
//
// Parameters
//   RECOVER_CYCLES  idle cycles after flash_halt_rd before the next grant (1..15)
//
// Build option
//   FLASH_ARB_ROUND_ROBIN_EN  when defined, simultaneous requests alternate
//                             (p0 first after reset); otherwise p0 always wins.
//
// Ports
//   clk, reset_n                 clock, async active-low reset
//   p0_req/p1_req                read request, held until done or abort
//   p0_addr/p1_addr [23:0]       start byte address, sampled at grant
//   p0_len/p1_len   [15:0]       byte count, sampled at grant
//   p0_gnt/p1_gnt                one-cycle grant pulse
//   p0_data/p1_data [7:0]        forwarded flash byte (0 when not strobed)
//   p0_valid/p1_valid            one-cycle byte strobe
//   p0_done/p1_done              one-cycle pulse with the last byte
//   flash_addr      [23:0]       latched address from ISSUE through HALT
//   flash_rd, flash_halt_rd      one-cycle start / stop pulses
//   flash_q [7:0], flash_q_valid byte from the flash and its strobe
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for a request; grants and latches the winner
// ISSUE    | flash_rd pulse with the latched address
// STREAM   | forwarding bytes to the owner until count expires or abort
// HALT     | flash_halt_rd pulse
// RECOVER  | down-counting RECOVER_CYCLES idle cycles before IDLE

module flash_read_arbiter #(
  parameter int RECOVER_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        p0_req,
  input  logic [23:0] p0_addr,
  input  logic [15:0] p0_len,
  output logic        p0_gnt,
  output logic [7:0]  p0_data,
  output logic        p0_valid,
  output logic        p0_done,
  input  logic        p1_req,
  input  logic [23:0] p1_addr,
  input  logic [15:0] p1_len,
  output logic        p1_gnt,
  output logic [7:0]  p1_data,
  output logic        p1_valid,
  output logic        p1_done,
  output logic [23:0] flash_addr,
  output logic        flash_rd,
  output logic        flash_halt_rd,
  input  logic [7:0]  flash_q,
  input  logic        flash_q_valid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_STREAM,
    S_HALT,
    S_RECOVER
  } state_t;

  state_t      state, state_nxt;
  logic [23:0] addr_q, addr_nxt;
  logic [15:0] rem_q, rem_nxt;
  logic        owner_q, owner_nxt;   // 0 = p0, 1 = p1
  logic [3:0]  rec_q, rec_nxt;

  logic        win_p1;
  logic        any_req;
  logic        owner_req;
  logic        cur_p1;
  logic        gnt_any, valid_any, done_any;
  logic [23:0] sel_addr;
  logic [15:0] sel_len;

  assign any_req = p0_req | p1_req;

`ifdef FLASH_ARB_ROUND_ROBIN_EN
  // Set when the most recent grant went to p0; p1 wins a tie only then.
  logic last_p0_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_p0_q <= 1'b0;
    end else if (state == S_IDLE && any_req) begin
      last_p0_q <= ~win_p1;
    end
  end

  assign win_p1 = p1_req & (~p0_req | last_p0_q);
`else
  assign win_p1 = p1_req & ~p0_req;
`endif

  assign sel_addr  = win_p1 ? p1_addr : p0_addr;
  assign sel_len   = win_p1 ? p1_len  : p0_len;
  assign owner_req = owner_q ? p1_req : p0_req;
  // In IDLE the grant goes to this cycle's winner; afterwards to the latched owner.
  assign cur_p1    = (state == S_IDLE) ? win_p1 : owner_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      owner_q <= 1'b0;
      rec_q   <= '0;
    end else begin
      state   <= state_nxt;
      addr_q  <= addr_nxt;
      rem_q   <= rem_nxt;
      owner_q <= owner_nxt;
      rec_q   <= rec_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    addr_nxt      = addr_q;
    rem_nxt       = rem_q;
    owner_nxt     = owner_q;
    rec_nxt       = rec_q;
    gnt_any       = 1'b0;
    valid_any     = 1'b0;
    done_any      = 1'b0;
    flash_rd      = 1'b0;
    flash_halt_rd = 1'b0;
    flash_addr    = '0;

    case (state)
      S_IDLE: begin
        if (any_req) begin
          gnt_any   = 1'b1;
          owner_nxt = win_p1;
          addr_nxt  = sel_addr;
          rem_nxt   = sel_len;
          // Zero-length reads complete at grant without touching the flash.
          if (sel_len == 16'd0) begin
            done_any = 1'b1;
          end else begin
            state_nxt = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        flash_rd   = 1'b1;
        flash_addr = addr_q;
        state_nxt  = S_STREAM;
      end
      S_STREAM: begin
        flash_addr = addr_q;
        // Abort takes precedence; a byte arriving in the abort cycle is dropped.
        if (!owner_req) begin
          state_nxt = S_HALT;
        end else if (flash_q_valid) begin
          valid_any = 1'b1;
          rem_nxt   = rem_q - 16'd1;
          if (rem_q == 16'd1) begin
            done_any  = 1'b1;
            state_nxt = S_HALT;
          end
        end
      end
      S_HALT: begin
        flash_addr    = addr_q;
        flash_halt_rd = 1'b1;
        rec_nxt       = 4'(RECOVER_CYCLES - 1);
        state_nxt     = S_RECOVER;
      end
      S_RECOVER: begin
        if (rec_q == 4'd0) begin
          state_nxt = S_IDLE;
        end else begin
          rec_nxt = rec_q - 4'd1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Gating with reset_n keeps a held request from showing a grant while in reset.
  assign p0_gnt   = reset_n & gnt_any   & ~cur_p1;
  assign p1_gnt   = reset_n & gnt_any   &  cur_p1;
  assign p0_valid = reset_n & valid_any & ~cur_p1;
  assign p1_valid = reset_n & valid_any &  cur_p1;
  assign p0_done  = reset_n & done_any  & ~cur_p1;
  assign p1_done  = reset_n & done_any  &  cur_p1;
  assign p0_data  = p0_valid ? flash_q : 8'h00;
  assign p1_data  = p1_valid ? flash_q : 8'h00;

endmodule

// File: tb/tb_flash_read_arbiter.sv
module tb_flash_read_arbiter;

  localparam int RC = 2;

  logic        clk;
  logic        reset_n;
  logic        p0_req, p1_req;
  logic [23:0] p0_addr, p1_addr;
  logic [15:0] p0_len, p1_len;
  logic        p0_gnt, p1_gnt, p0_valid, p1_valid, p0_done, p1_done;
  logic [7:0]  p0_data, p1_data;
  logic [23:0] flash_addr;
  logic        flash_rd, flash_halt_rd;
  logic [7:0]  flash_q;
  logic        flash_q_valid;

  flash_read_arbiter #(.RECOVER_CYCLES(RC)) dut (
    .clk(clk), .reset_n(reset_n),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_len(p0_len),
    .p0_gnt(p0_gnt), .p0_data(p0_data), .p0_valid(p0_valid), .p0_done(p0_done),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_len(p1_len),
    .p1_gnt(p1_gnt), .p1_data(p1_data), .p1_valid(p1_valid), .p1_done(p1_done),
    .flash_addr(flash_addr), .flash_rd(flash_rd), .flash_halt_rd(flash_halt_rd),
    .flash_q(flash_q), .flash_q_valid(flash_q_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // scoreboard: expected bytes per port, pushed when driven, popped on valid
  logic [7:0] sq0[$];
  logic [7:0] sq1[$];
  logic [7:0] tb_bytes[$];

  int cyc = 0;
  int n_valid0 = 0, n_valid1 = 0, n_done0 = 0, n_done1 = 0;
  int n_gnt = 0, n_rd = 0, n_halt = 0;
  int gnt_cyc = 0, gnt_port = -1, halt_cyc = 0, done_cyc = 0;
  logic [7:0] done_data = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {24'h0, p0_gnt, p0_valid, p0_done, p1_gnt, p1_valid, p1_done,
                        flash_rd, flash_halt_rd}, 32'h0);
    chk({tag, "_data"}, {16'h0, p0_data, p1_data}, 32'h0);
    chk({tag, "_faddr"}, {8'h0, flash_addr}, 32'h0);
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (p0_valid) begin
        n_valid0++;
        if (sq0.size() == 0) chk("p0_unexpected_valid", p0_valid, 0);
        else chk("p0_data", p0_data, sq0.pop_front());
      end else begin
        chk("p0_data_quiet", p0_data, 0);
      end
      if (p1_valid) begin
        n_valid1++;
        if (sq1.size() == 0) chk("p1_unexpected_valid", p1_valid, 0);
        else chk("p1_data", p1_data, sq1.pop_front());
      end else begin
        chk("p1_data_quiet", p1_data, 0);
      end
      chk("one_gnt_max", {30'h0, p0_gnt, p1_gnt} == 2'b11, 0);
      if (p0_done) begin n_done0++; done_cyc = cyc; done_data = p0_data; end
      if (p1_done) begin n_done1++; done_cyc = cyc; done_data = p1_data; end
      if (p0_gnt) begin n_gnt++; gnt_cyc = cyc; gnt_port = 0; end
      if (p1_gnt) begin n_gnt++; gnt_cyc = cyc; gnt_port = 1; end
      if (flash_rd) n_rd++;
      if (flash_halt_rd) begin n_halt++; halt_cyc = cyc; end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rd(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (flash_rd === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("flash_rd_timeout", flash_rd, 1);
  endtask

  // Serve one transaction: wait for flash_rd, stream tb_bytes, optionally abort.
  task automatic serve(input int port, input logic [23:0] addr, input bit abort);
    bit ok;
    int v0, d0;
    v0 = port ? n_valid1 : n_valid0;
    d0 = port ? n_done1 : n_done0;
    wait_rd(ok);
    if (ok) begin
      chk("issue_addr", {8'h0, flash_addr}, {8'h0, addr});
      chk("gnt_port", gnt_port, port);
      chk("gnt_to_rd", cyc - gnt_cyc, 1);
      for (int i = 0; i < tb_bytes.size(); i++) begin
        step();
        if (port == 0) sq0.push_back(tb_bytes[i]);
        else sq1.push_back(tb_bytes[i]);
        flash_q = tb_bytes[i];
        flash_q_valid = 1'b1;
      end
      step();
      if (abort) begin
        if (port == 0) p0_req = 1'b0;
        else p1_req = 1'b0;
        flash_q = 8'hEE;
        flash_q_valid = 1'b1;
        step();
      end
      flash_q_valid = 1'b0;
      flash_q = 8'h00;
      chk("valid_count", (port ? n_valid1 : n_valid0) - v0, tb_bytes.size());
      chk("done_count", (port ? n_done1 : n_done0) - d0, abort ? 0 : 1);
    end
  endtask

  initial begin
    int order[4];
    int cnt[2];
    int rd0, h0, v0, d0;
    bit ok;

    reset_n = 1'b0;
    p0_req = 1'b1; p1_req = 1'b0;
    p0_addr = 24'h0; p1_addr = 24'h0; p0_len = 16'h0; p1_len = 16'h0;
    flash_q = 8'h00; flash_q_valid = 1'b0;
    repeat (3) step();
    chk_zero("reset");
    p0_req = 1'b0;
    step();
    reset_n = 1'b1;
    step();

    // Both held for two transactions each
`ifdef FLASH_ARB_ROUND_ROBIN_EN
    order = '{0, 1, 0, 1};
`else
    order = '{0, 0, 1, 1};
`endif
    cnt = '{2, 2};
    p0_len = 16'd2; p1_len = 16'd1;
    for (int k = 0; k < 4; k++) begin
      p0_addr = 24'h000100 + 24'(k);
      p1_addr = 24'h000200 + 24'(k);
      if (k == 0) begin p0_req = 1'b1; p1_req = 1'b1; end
      tb_bytes = {};
      if (order[k] == 0) begin
        tb_bytes.push_back(8'(8'h10 + k));
        tb_bytes.push_back(8'(8'h20 + k));
      end else begin
        tb_bytes.push_back(8'(8'h30 + k));
      end
      serve(order[k], order[k] ? p1_addr : p0_addr, 1'b0);
      if (k > 0) chk("recover_gap", gnt_cyc - halt_cyc, RC + 1);
      cnt[order[k]]--;
      if (cnt[order[k]] == 0) begin
        if (order[k] == 0) p0_req = 1'b0;
        else p1_req = 1'b0;
      end
    end
    repeat (6) step();

    // p0 single read, three bytes
    rd0 = n_rd; h0 = n_halt;
    p0_addr = 24'hF01893; p0_len = 16'd3; p0_req = 1'b1;
    tb_bytes = '{8'hE2, 8'hA3, 8'hB6};
    serve(0, 24'hF01893, 1'b0);
    p0_req = 1'b0;
    @(negedge clk); #1;
    chk("t1_done_data", done_data, 8'hB6);
    chk("t1_halt_after_done", halt_cyc - done_cyc, 1);
    chk("t1_rd_count", n_rd - rd0, 1);
    chk("t1_halt_count", n_halt - h0, 1);
    repeat (6) step();

    // p1 zero-length
    rd0 = n_rd;
    p1_len = 16'd0; p1_addr = 24'h00AAAA; p1_req = 1'b1;
    @(negedge clk);
    chk("len0_gnt", {p1_gnt, p1_done, flash_rd}, 3'b110);
    step();
    p1_req = 1'b0;
    repeat (4) step();
    chk("len0_no_rd", n_rd - rd0, 0);

    // p0 abort after 5 of 100 bytes
    h0 = n_halt;
    p0_addr = 24'h004000; p0_len = 16'd100; p0_req = 1'b1;
    tb_bytes = '{8'h01, 8'h12, 8'h23, 8'h34, 8'h45};
    serve(0, 24'h004000, 1'b1);
    @(negedge clk); #1;
    chk("abort_halt", n_halt - h0, 1);
    repeat (6) step();

    // reset in the middle of a 4-byte stream
    h0 = n_halt;
    p0_addr = 24'h123456; p0_len = 16'd4; p0_req = 1'b1;
    wait_rd(ok);
    for (int i = 0; i < 2; i++) begin
      step();
      sq0.push_back(8'(8'hC0 + i));
      flash_q = 8'(8'hC0 + i);
      flash_q_valid = 1'b1;
    end
    step();
    flash_q = 8'h55;
    reset_n = 1'b0;
    #1;
    chk_zero("reset_mid");
    p0_req = 1'b0; flash_q_valid = 1'b0; flash_q = 8'h00;
    repeat (3) step();
    chk("reset_no_halt", n_halt - h0, 0);
    reset_n = 1'b1;
    rd0 = n_rd;
    p1_addr = 24'hABCDEF; p1_len = 16'd1; p1_req = 1'b1;
    tb_bytes = '{8'h77};
    serve(1, 24'hABCDEF, 1'b0);
    p1_req = 1'b0;
    chk("post_reset_rd", n_rd - rd0, 1);
    repeat (6) step();

    chk("sb_empty", sq0.size() + sq1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
